fp_mul_seq: RTL and testbench
=============================

Name: fp_mul_seq

Overview:
Parametrised, sequential IEEE-754 binary multiplier, successor to the combinational single-precision multiplier in the FP unit. It multiplies mantissas with an iterative radix-2 shift-add datapath, normalises, and rounds to nearest-even. It handles zero, infinity, NaN, overflow and underflow, and flushes subnormals. It sits behind a valid/ready handshake so the FP unit can stall it.

Parameters:
EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1
MANT_WIDTH, 23, stored fraction width (hidden bit excluded)
DATA_WIDTH, EXP_WIDTH+MANT_WIDTH+1, operand/result width

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present on in_numA/in_numB
out_ready  output  1  block can accept operands (high only in IDLE)
in_numA  input  DATA_WIDTH  operand A {sign, exp, frac}
in_numB  input  DATA_WIDTH  operand B
out_valid  output  1  out_result holds a finished product
in_ready  input  1  downstream accepts out_result
out_result  output  DATA_WIDTH  product

Behaviour:
- Reset (async, in_rst_n=0): state=IDLE; out_valid=0; out_result=0; counter, accumulator and operand registers cleared; out_ready=1 once reset is released. Reset mid-operation aborts with no output.
- States: IDLE -> MULT -> NORM -> DONE -> IDLE.
- IDLE: on in_valid&&out_ready, latch operands and classify each as zero (exp=0, including subnormal flush), inf (exp=all-ones, frac=0), NaN (exp=all-ones, frac!=0) or normal. Sign = signA^signB. Clear the accumulator, load counter=0, go to MULT.
- MULT: each cycle adds the multiplicand (1.fracA) shifted by the counter into a 2*(MANT_WIDTH+1)-bit accumulator when multiplier bit [counter] of 1.fracB is set. Runs exactly MANT_WIDTH+1 cycles, then goes to NORM.
- NORM (one cycle):
  - Exponent sum uses EXP_WIDTH+2-bit signed: eA+eB-bias.
  - If product MSB=1, take the upper field and exp+1; otherwise shift left by 1.
  - Guard = next bit; sticky = OR of the remaining bits. Round to nearest-even.
  - A rounding carry-out sets the fraction to 0 and adds 1 to the exponent.
  - Final exp >= all-ones -> signed inf. Final exp <= 0 -> signed zero (flush).
- Special-case priority: NaN in, or inf×zero -> canonical qNaN (sign 0, exp all-ones, frac MSB=1, rest 0). Otherwise inf in -> signed inf. Otherwise zero in -> signed zero.
- Latency is fixed regardless of operand class: out_valid rises MANT_WIDTH+2 rising edges after the accepting edge (25 for the defaults).
- DONE: out_valid=1 and out_result stable until in_ready=1 is sampled. Then go to IDLE with out_valid=0 on the next edge. in_ready held low stalls the block indefinitely.
- out_ready=0 in MULT/NORM/DONE, so operands presented then are ignored, not queued. Throughput is one operation per MANT_WIDTH+4 cycles minimum.
- out_result is registered and holds its last value in IDLE.

Optional Feature:
FP_MUL_FLAGS_EN: adds output port out_flags [3:0] = {invalid, overflow, underflow, inexact}, registered alongside out_result and valid with out_valid. Flags are reset to 0.
- invalid = qNaN generated from inf×zero or a NaN operand.
- overflow = finite operands rounded to inf.
- underflow = nonzero finite operands flushed to zero.
- inexact = guard|sticky nonzero, or overflow/underflow.
Without the macro the port and its logic are absent and the result is unchanged.

Test Plan:
- Defaults, A=0x3FC00000 (1.5), B=0x40000000 (2.0), in_ready=1 -> out_valid exactly 25 edges after accept, out_result=0x40400000. Repeat with A=0xC0000000, B=0x40400000 -> 0xC0C00000.
- Rounding: A=B=0x3F800001 -> 0x3F800002, inexact=1 with FP_MUL_FLAGS_EN.
- Specials: 0x7F800000×0x00000000 -> 0x7FC00000, invalid=1. 0xFF800000×0x40000000 -> 0xFF800000. 0x7FC00001×0x3F800000 -> 0x7FC00000. All take the same 25-edge latency.
- Range: 0x7F000000×0x7F000000 -> 0x7F800000, overflow=1. 0x00800000×0x00800000 -> 0x00000000, underflow=1. Subnormal 0x00000001×0x3F800000 -> 0x00000000.
- Handshake: hold in_ready=0 for 10 cycles after out_valid -> result stable, out_ready=0, a new in_valid is ignored. Raise in_ready -> out_valid=0 and out_ready=1 next edge.
- Reset: assert in_rst_n=0 at MULT cycle 10 -> out_valid=0 and out_result=0 immediately. After release, 1.5×2.0 completes correctly.

Source files
------------

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier: radix-2 shift-add mantissa product, normalise, round-to-nearest-even.
// Define FP_MUL_FLAGS_EN to add the out_flags port {invalid, overflow, underflow, inexact}.
module fp_mul_seq #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int DATA_WIDTH = EXP_WIDTH + MANT_WIDTH + 1
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_numA,
    input  logic [DATA_WIDTH-1:0] in_numB,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [1:0]            out_dbg_state,
`ifdef FP_MUL_FLAGS_EN
    output logic [3:0]            out_flags,
`endif
    output logic [DATA_WIDTH-1:0] out_result
);
    localparam int MW1      = MANT_WIDTH + 1;
    localparam int PW       = 2 * MW1;
    localparam int EW2      = EXP_WIDTH + 2;
    localparam int CNT_W    = $clog2(MW1);
    localparam int EXP_ALL1 = (1 << EXP_WIDTH) - 1;
    localparam int BIAS     = (1 << (EXP_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [PW-1:0]           r_acc;
    logic [PW-1:0]           r_mcand;
    logic [MW1-1:0]          r_mplier;
    logic [EXP_WIDTH-1:0]    r_expa;
    logic [EXP_WIDTH-1:0]    r_expb;
    logic                    r_sign;
    logic                    r_nan;
    logic                    r_inf;
    logic                    r_zero;
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_result;

    // Operand classification; exp==0 covers true zero and flushed subnormals.
    logic [EXP_WIDTH-1:0]  w_expa, w_expb;
    logic [MANT_WIDTH-1:0] w_fraca, w_fracb;
    logic                  w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;

    assign w_expa   = in_numA[DATA_WIDTH-2 -: EXP_WIDTH];
    assign w_expb   = in_numB[DATA_WIDTH-2 -: EXP_WIDTH];
    assign w_fraca  = in_numA[MANT_WIDTH-1:0];
    assign w_fracb  = in_numB[MANT_WIDTH-1:0];
    assign w_zero_a = (w_expa == '0);
    assign w_zero_b = (w_expb == '0);
    assign w_inf_a  = (&w_expa) && (w_fraca == '0);
    assign w_inf_b  = (&w_expb) && (w_fracb == '0);
    assign w_nan_a  = (&w_expa) && (|w_fraca);
    assign w_nan_b  = (&w_expb) && (|w_fracb);

    // Normalise: product is in [1,4) so at most a one-bit adjustment is needed.
    logic [PW-2:0]         w_norm;
    logic [MANT_WIDTH-1:0] w_mant;
    logic                  w_guard, w_sticky, w_round_up, w_carry;
    logic [MANT_WIDTH:0]   w_mant_r;
    logic [EW2-1:0]        w_exp_sum, w_exp_fin;
    logic                  w_ovf, w_unf;
    logic [DATA_WIDTH-1:0] w_next_result;

    assign w_norm     = r_acc[PW-1] ? r_acc[PW-2:0] : {r_acc[PW-3:0], 1'b0};
    assign w_mant     = w_norm[PW-2 -: MANT_WIDTH];
    assign w_guard    = w_norm[PW-2-MANT_WIDTH];
    assign w_sticky   = |w_norm[PW-3-MANT_WIDTH:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_r   = {1'b0, w_mant} + {{MANT_WIDTH{1'b0}}, w_round_up};
    assign w_carry    = w_mant_r[MANT_WIDTH];
    assign w_exp_sum  = {2'b00, r_expa} + {2'b00, r_expb} - EW2'(BIAS);
    assign w_exp_fin  = w_exp_sum + EW2'(r_acc[PW-1]) + EW2'(w_carry);
    assign w_ovf      = !w_exp_fin[EW2-1] && (w_exp_fin >= EW2'(EXP_ALL1));
    assign w_unf      = w_exp_fin[EW2-1] || (w_exp_fin == '0);

    always_comb begin
        w_next_result = '0;
        if (r_nan)
            w_next_result = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
        else if (r_inf || (!r_zero && w_ovf))
            w_next_result = {r_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        else if (r_zero || w_unf)
            w_next_result = {r_sign, {(DATA_WIDTH-1){1'b0}}};
        else
            w_next_result = {r_sign, w_exp_fin[EXP_WIDTH-1:0], w_mant_r[MANT_WIDTH-1:0]};
    end

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] w_next_flags;

    always_comb begin
        w_next_flags = 4'b0000;
        if (r_nan)
            w_next_flags = 4'b1000;
        else if (!r_inf && !r_zero)
            w_next_flags = {1'b0, w_ovf, w_unf, w_ovf | w_unf | w_guard | w_sticky};
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n)
            r_flags <= 4'b0000;
        else if (r_state == ST_NORM)
            r_flags <= w_next_flags;
    end

    assign out_flags = r_flags;
`endif

    // Handshake: input accepted on an edge where in_valid && out_ready; result
    // consumed on an edge where out_valid && in_ready; out_result holds otherwise.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_expa   <= '0;
            r_expb   <= '0;
            r_sign   <= 1'b0;
            r_nan    <= 1'b0;
            r_inf    <= 1'b0;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_ready) begin
                        r_expa   <= w_expa;
                        r_expb   <= w_expb;
                        r_sign   <= in_numA[DATA_WIDTH-1] ^ in_numB[DATA_WIDTH-1];
                        r_nan    <= w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_inf_b && w_zero_a);
                        r_inf    <= w_inf_a || w_inf_b;
                        r_zero   <= w_zero_a || w_zero_b;
                        r_mcand  <= {{MW1{1'b0}}, 1'b1, w_fraca};
                        r_mplier <= {1'b1, w_fracb};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (r_mplier[0])
                        r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(MANT_WIDTH))
                        r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_result <= w_next_result;
                    r_valid  <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (in_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_ready     = r_ready;
    assign out_valid     = r_valid;
    assign out_result    = r_result;
    assign out_dbg_state = r_state;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq (default parameters): vector table plus handshake-stall and reset-abort sequences.
module tb_fp_mul_seq;
    localparam int LAT      = 25;
    localparam int LAT_MAX  = 60;

    logic        in_clk = 1'b0;
    logic        in_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic [31:0] in_numA = '0;
    logic [31:0] in_numB = '0;
    logic        out_valid;
    logic        in_ready = 1'b1;
    logic [1:0]  out_dbg_state;
    logic [31:0] out_result;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    fp_mul_seq dut (
        .in_clk        (in_clk),
        .in_rst_n      (in_rst_n),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .in_numA       (in_numA),
        .in_numB       (in_numB),
        .out_valid     (out_valid),
        .in_ready      (in_ready),
        .out_dbg_state (out_dbg_state),
`ifdef FP_MUL_FLAGS_EN
        .out_flags     (out_flags),
`endif
        .out_result    (out_result)
    );

    // Clock and watchdog
    always #5 in_clk = ~in_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, state=%0d", out_dbg_state);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        bit          chk_flags;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drivers: all stimulus changes happen 1 time unit after a rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!out_ready && n < LAT_MAX) begin
            @(posedge in_clk); #1;
            n++;
        end
        check("ready_before_send", 32'(out_ready), 32'd1);
        in_valid = 1'b1;
        in_numA  = a;
        in_numB  = b;
        @(posedge in_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < LAT_MAX) begin
            @(posedge in_clk); #1;
            lat++;
        end
    endtask

    // Scoreboard
    task automatic sb_pop(input string name);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got result %h with no expected entry", name, out_result);
        end else begin
            check(name, out_result, exp_q.pop_front());
        end
    endtask

    task automatic do_vec(input int i);
        int lat;
        exp_q.push_back(vecs[i].res);
        send(vecs[i].a, vecs[i].b);
        wait_valid(lat);
        check({vecs[i].name, "_latency"}, 32'(lat), 32'(LAT));
        sb_pop(vecs[i].name);
`ifdef FP_MUL_FLAGS_EN
        if (vecs[i].chk_flags)
            check({vecs[i].name, "_flags"}, {28'd0, out_flags}, {28'd0, vecs[i].flags});
`endif
        @(posedge in_clk); #1;
    endtask

    initial begin
        int lat;
        bit saw_valid;

        vecs[0]  = '{"mul_1p5_2",     32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1};
        vecs[1]  = '{"mul_m2_3",      32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 1'b1};
        vecs[2]  = '{"mul_3_3",       32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 1'b1};
        vecs[3]  = '{"round_sticky",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 1'b1};
        vecs[4]  = '{"round_up",      32'h3FC00001, 32'h3FC00000, 32'h40100001, 4'b0001, 1'b1};
        vecs[5]  = '{"tie_even_keep", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 1'b1};
        vecs[6]  = '{"tie_even_up",   32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 1'b1};
        vecs[7]  = '{"inf_x_zero",    32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[8]  = '{"neg_inf_x_2",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1'b1};
        vecs[9]  = '{"nan_in",        32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[10] = '{"overflow",      32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 1'b1};
        vecs[11] = '{"underflow",     32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 1'b1};
        vecs[12] = '{"subnormal_in",  32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1'b0};

        // Reset block
        in_rst_n = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", out_result, 32'd0);
        in_rst_n = 1'b1;
        @(posedge in_clk); #1;
        check("rst_ready", 32'(out_ready), 32'd1);
`ifdef FP_MUL_FLAGS_EN
        check("rst_flags", {28'd0, out_flags}, 32'd0);
`endif

        for (int i = 0; i < 13; i++)
            do_vec(i);

        // Downstream stall: result must hold and new operands must be ignored.
        in_ready = 1'b0;
        exp_q.push_back(32'h40400000);
        send(32'h3FC00000, 32'h40000000);
        wait_valid(lat);
        check("stall_latency", 32'(lat), 32'(LAT));
        in_valid = 1'b1;
        in_numA  = 32'h40400000;
        in_numB  = 32'h40400000;
        for (int c = 0; c < 10; c++) begin
            check("stall_result", out_result, 32'h40400000);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_ready", 32'(out_ready), 32'd0);
            @(posedge in_clk); #1;
        end
        in_valid = 1'b0;
        sb_pop("stall_pop");
        in_ready = 1'b1;
        @(posedge in_clk); #1;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(out_ready), 32'd1);
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) saw_valid = 1'b1;
            @(posedge in_clk); #1;
        end
        check("no_queued_op", 32'(saw_valid), 32'd0);

        // Reset in the middle of MULT aborts with no output.
        send(32'h40400000, 32'h40400000);
        repeat (10) begin
            @(posedge in_clk); #1;
        end
        in_rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_result", out_result, 32'd0);
        repeat (2) @(posedge in_clk);
        #1;
        in_rst_n = 1'b1;
        @(posedge in_clk); #1;
        saw_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) saw_valid = 1'b1;
            @(posedge in_clk); #1;
        end
        check("abort_no_output", 32'(saw_valid), 32'd0);
        do_vec(0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
